ps2_key_decoder: RTL

- Sequences the raw PS/2 byte receiver output into complete key events.
- Collapses the E0 (extended) and F0 (break) prefix bytes into single make/break events.
- Buffers events in a small FIFO with a valid/ready handshake for the game logic.
- Maintains held-state levels for the four arrow keys; sits between the PS/2 byte receiver and the Sokoban move controller.

---
 rtl/ps2_pkg.sv | 57 +++++
 rtl/key_evt_fifo.sv | 69 ++++++
 rtl/ps2_key_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state encoding and key-event record
// for the PS/2 key decoder and its event FIFO.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERR1  = 8'hFF;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  localparam int EVT_W = 10;

  function automatic evt_t mk_evt(input logic ext, input logic brk, input logic [7:0] code);
    evt_t e;
    e.ext  = ext;
    e.brk  = brk;
    e.code = code;
    return e;
  endfunction

  // Pause and keyboard error/overrun bytes abort any partial sequence.
  function automatic logic is_dropped(input logic [7:0] b);
    return (b == SC_PAUSE) || (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

  // Bit order {up,down,left,right} to match dir_held.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_UP:    m = 4'b1000;
      SC_DOWN:  m = 4'b0100;
      SC_LEFT:  m = 4'b0010;
      SC_RIGHT: m = 4'b0001;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Show-ahead DEPTH x W FIFO with registered head/empty; push is honoured when full
// only if a pop happens on the same edge, otherwise the caller sees o_full and drops.
module key_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_vld;
  logic [W-1:0]  r_head;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [W-1:0]  w_head_nxt;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = i_pop & r_vld;
  assign w_push = i_push & (~w_full | w_pop);

  // Head after this edge: bypass the write when it lands on the new read slot.
  always_comb begin
    w_rptr_nxt = w_pop ? r_rptr + AW'(1) : r_rptr;
    w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    w_head_nxt = (w_push && (r_wptr == w_rptr_nxt)) ? i_dat : r_mem[w_rptr_nxt];
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= 1'b0;
      r_head  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_dat;
        r_wptr        <= r_wptr + AW'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_cnt_nxt;
      r_vld   <= (w_cnt_nxt != '0);
      r_head  <= (w_cnt_nxt != '0) ? w_head_nxt : '0;
    end
  end

  assign o_dat   = r_head;
  assign o_full  = w_full;
  assign o_empty = ~r_vld;

endmodule

// File: rtl/ps2_key_decoder.sv
// Folds E0/F0-prefixed PS/2 bytes into make/break key events, queued for the game
// logic; event visible 2 cycles after the byte strobe, dropped (sticky overflow) when full.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       scan_code_ready,
  input  logic [7:0] scan_code,
  input  logic       parity_xor,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [3:0] dir_held,
  output logic       overflow,
  output logic       bad_frame
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           r_state;
  logic             r_rdy_d;
  logic [TW-1:0]    r_tmo;
  logic             r_emit_vld;
  evt_t             r_emit;
  logic             r_bad;
  logic [3:0]       r_dir;
  logic             r_overflow;

  logic             w_byte_stb;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [EVT_W-1:0] w_head_dat;
  evt_t             w_head;

  assign w_byte_stb = scan_code_ready & ~r_rdy_d;

  // r_rdy_d resets high so a level already present at reset release is ignored.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_rdy_d    <= 1'b1;
      r_state    <= ST_IDLE;
      r_tmo      <= '0;
      r_emit_vld <= 1'b0;
      r_emit     <= '0;
      r_bad      <= 1'b0;
    end else begin
      r_rdy_d    <= scan_code_ready;
      r_emit_vld <= 1'b0;
      r_bad      <= 1'b0;
      if (w_byte_stb) begin
        r_tmo <= '0;
        if (!parity_xor) begin
          r_bad   <= 1'b1;
          r_state <= ST_IDLE;
        end else if (is_dropped(scan_code)) begin
          r_state <= ST_IDLE;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (scan_code == SC_EXT)      r_state <= ST_EXT;
              else if (scan_code == SC_BRK) r_state <= ST_BRK;
              else begin
                r_emit_vld <= 1'b1;
                r_emit     <= mk_evt(1'b0, 1'b0, scan_code);
              end
            end
            ST_EXT: begin
              if (scan_code == SC_BRK)      r_state <= ST_EXT_BRK;
              else if (scan_code == SC_EXT) r_state <= ST_EXT;
              else begin
                r_emit_vld <= 1'b1;
                r_emit     <= mk_evt(1'b1, 1'b0, scan_code);
                r_state    <= ST_IDLE;
              end
            end
            ST_BRK: begin
              r_emit_vld <= 1'b1;
              r_emit     <= mk_evt(1'b0, 1'b1, scan_code);
              r_state    <= ST_IDLE;
            end
            default: begin
              r_emit_vld <= 1'b1;
              r_emit     <= mk_evt(1'b1, 1'b1, scan_code);
              r_state    <= ST_IDLE;
            end
          endcase
        end
      end else if (r_state != ST_IDLE) begin
        if (r_tmo == TW'(TIMEOUT - 1)) begin
          r_state <= ST_IDLE;
          r_tmo   <= '0;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

  assign w_pop = evt_valid & evt_ready;

  // Held-key levels track every emitted event, including ones the FIFO drops.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_dir      <= 4'b0000;
      r_overflow <= 1'b0;
    end else begin
      if (r_emit_vld && r_emit.ext) begin
        if (r_emit.brk) r_dir <= r_dir & ~arrow_mask(r_emit.code);
        else            r_dir <= r_dir | arrow_mask(r_emit.code);
      end
      if (r_emit_vld && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  key_evt_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .sys_clk (sys_clk),
    .reset   (reset),
    .i_push  (r_emit_vld),
    .i_dat   (r_emit),
    .i_pop   (w_pop),
    .o_dat   (w_head_dat),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head    = evt_t'(w_head_dat);
  assign evt_valid = ~w_empty;
  assign evt_code  = w_head.code;
  assign evt_ext   = w_head.ext;
  assign evt_break = w_head.brk;
  assign dir_held  = r_dir;
  assign overflow  = r_overflow;
  assign bad_frame = r_bad;

endmodule
